ttm4_alu: RTL and testbench
===========================

Name: ttm4_alu

Overview:
4-bit arithmetic/logic unit for the TTM4 CPU emulator datapath.
- Combines operand X with a second operand chosen by SEL (register Y, immediate IM, or a constant).
- Performs the one operation requested by the active-low enable strobes.
- Drives the result onto STOREBUS for register write-back.
- Registers zero and carry flags for later conditional branches.

Parameters:
none (datapath width fixed at 4 bits)

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  synchronous reset, active-high
X  in  4  operand A (register X)
Y  in  4  register Y, operand B candidate
IM  in  4  instruction immediate, operand B candidate
SEL  in  2  operand B select
nFA_EN  in  1  active-low: full-adder result (A+B)
nAND_EN  in  1  active-low: A AND B
nOR_EN  in  1  active-low: A OR B
nXOR_EN  in  1  active-low: A XOR B
Z_FLAG  out  1  registered zero flag
C_FLAG  out  1  registered carry flag
STOREBUS  out  4  combinational result bus

Behaviour:
- Operand A is always X.
- Operand B by SEL:
  - 00: Y
  - 01: IM
  - 10: 4'b0001 (increment)
  - 11: 4'b0000 (pass X)
- Add: 5-bit sum {carry, sum[3:0]} = A + B, unsigned, no carry-in. Result is sum[3:0] and wraps modulo 16; carry = bit 4.
- Logic ops are bitwise on 4 bits; their carry is 0.
- Operation select is a priority decode of the active (low) enables: FA > AND > OR > XOR. The lower-priority strobes are ignored when several are low.
- No enable low (all four high):
  - STOREBUS = 4'b0000 (idle bus).
  - Flags hold their value.
- STOREBUS is purely combinational from X, Y, IM, SEL and the enables. It reflects changes in the same cycle with zero latency and is not affected by RST.
- Flags register on the rising CLK edge:
  - if RST=1: Z_FLAG<=0, C_FLAG<=0. Reset has priority over any operation in the same cycle.
  - else if any enable is low: Z_FLAG <= (result[3:0]==0) and C_FLAG <= carry of the selected operation. C is 0 for AND/OR/XOR.
  - else: hold.
- Flag latency: 1 cycle after the operation is presented.
- Reset mid-operation: flags clear on that edge. The next non-reset edge with an enable asserted loads fresh flags.
- At power-up, before the first reset, the flags are undefined. The bench must apply reset before checking flags.
- Z is computed on the 4-bit result, so an add wrapping to 0 gives Z=1 and C=1.
- Inputs are assumed stable around the clock edge. No internal state other than the two flag bits.

Test Plan:
1. RST=1 for 4 cycles with nFA_EN=0 -> Z_FLAG=0, C_FLAG=0 throughout. First edge after release with X=0101, Y=1010, SEL=00 -> STOREBUS=1111, Z=0, C=0.
2. X=0101, IM=1100, SEL=01:
   - nFA_EN=0 -> STOREBUS=0001, next edge C=1, Z=0.
   - nAND_EN=0 -> 0100, C=0.
   - nOR_EN=0 -> 1101.
   - nXOR_EN=0 -> 1001, C=0, Z=0.
3. X=0101, Y=1010, SEL=00:
   - nAND_EN=0 -> STOREBUS=0000, Z=1, C=0.
   - nOR_EN=0 -> 1111, Z=0.
   - nXOR_EN=0 -> 1111.
4. All enables high after a C=1 operation -> STOREBUS=0000, Z_FLAG/C_FLAG unchanged over 3 cycles.
5. Priority: nFA_EN=0 and nAND_EN=0, X=0101, Y=1010, SEL=00 -> STOREBUS=1111 (add result). nOR_EN=0 and nXOR_EN=0 -> OR result.
6. SEL=10, X=1111, nFA_EN=0 -> STOREBUS=0000, next edge Z=1, C=1. Assert RST in the following cycle -> both flags 0.

Source files
------------

// File: rtl/ttm4_alu.sv
// ttm4_alu: 4-bit ALU for the TTM4 CPU emulator datapath.
// Operand A is X; operand B is chosen by SEL. One operation is selected by a
// priority decode of active-low strobes (FA > AND > OR > XOR). The result is
// driven combinationally onto STOREBUS; zero/carry flags are registered.
module ttm4_alu (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [3:0] IM,
  input  logic [1:0] SEL,
  input  logic       nFA_EN,
  input  logic       nAND_EN,
  input  logic       nOR_EN,
  input  logic       nXOR_EN,
  output logic       Z_FLAG,
  output logic       C_FLAG,
  output logic [3:0] STOREBUS
);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4
  } op_e;

  logic [3:0] operand_b_s;
  op_e        op_s;
  logic [3:0] result_s;
  logic       carry_s;
  logic [4:0] sum_s;
  logic       z_flag_r;
  logic       c_flag_r;

  // Select operand B: register Y, immediate, constant one (increment) or zero (pass X)
  always_comb begin
    operand_b_s = 4'b0000;
    case (SEL)
      2'b00:   operand_b_s = Y;
      2'b01:   operand_b_s = IM;
      2'b10:   operand_b_s = 4'b0001;
      2'b11:   operand_b_s = 4'b0000;
      default: operand_b_s = 4'b0000;
    endcase
  end

  // Priority-decode the active-low strobes; lower-priority strobes are ignored
  always_comb begin
    op_s = OP_NONE;
    if (!nFA_EN) begin
      op_s = OP_ADD;
    end else if (!nAND_EN) begin
      op_s = OP_AND;
    end else if (!nOR_EN) begin
      op_s = OP_OR;
    end else if (!nXOR_EN) begin
      op_s = OP_XOR;
    end else begin
      op_s = OP_NONE;
    end
  end

  // Compute the selected operation; idle bus is zero and logic ops never carry
  always_comb begin
    sum_s    = {1'b0, X} + {1'b0, operand_b_s};
    result_s = 4'b0000;
    carry_s  = 1'b0;
    case (op_s)
      OP_ADD: begin
        result_s = sum_s[3:0];
        carry_s  = sum_s[4];
      end
      OP_AND:  result_s = X & operand_b_s;
      OP_OR:   result_s = X | operand_b_s;
      OP_XOR:  result_s = X ^ operand_b_s;
      OP_NONE: result_s = 4'b0000;
      default: result_s = 4'b0000;
    endcase
  end

  // Flags: reset wins, otherwise load on any active operation, else hold for branches
  always_ff @(posedge CLK) begin
    if (RST) begin
      z_flag_r <= 1'b0;
      c_flag_r <= 1'b0;
    end else if (op_s != OP_NONE) begin
      z_flag_r <= (result_s == 4'b0000);
      c_flag_r <= carry_s;
    end else begin
      z_flag_r <= z_flag_r;
      c_flag_r <= c_flag_r;
    end
  end

  assign STOREBUS = result_s;
  assign Z_FLAG   = z_flag_r;
  assign C_FLAG   = c_flag_r;

endmodule

// File: tb/tb_ttm4_alu.sv
// tb_ttm4_alu: directed test-plan scenarios followed by randomized stimulus,
// all checked against an arithmetic reference model of the ALU.
module tb_ttm4_alu;

  logic       tb_CLK;
  logic       tb_RST;
  logic [3:0] tb_X, tb_Y, tb_IM;
  logic [1:0] tb_SEL;
  logic       tb_nFA_EN, tb_nAND_EN, tb_nOR_EN, tb_nXOR_EN;
  logic       tb_Z_FLAG, tb_C_FLAG;
  logic [3:0] tb_STOREBUS;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference flag state, tracked only after a reset has been applied
  bit model_z = 1'b0;
  bit model_c = 1'b0;

  ttm4_alu dut (
    .CLK      (tb_CLK),
    .RST      (tb_RST),
    .X        (tb_X),
    .Y        (tb_Y),
    .IM       (tb_IM),
    .SEL      (tb_SEL),
    .nFA_EN   (tb_nFA_EN),
    .nAND_EN  (tb_nAND_EN),
    .nOR_EN   (tb_nOR_EN),
    .nXOR_EN  (tb_nXOR_EN),
    .Z_FLAG   (tb_Z_FLAG),
    .C_FLAG   (tb_C_FLAG),
    .STOREBUS (tb_STOREBUS)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    tb_CLK = 1'b0;
    forever #5 tb_CLK = ~tb_CLK;
  end

  task automatic check_val(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: plain integer arithmetic on the chosen operands.
  // en = {nFA, nAND, nOR, nXOR}.
  function automatic void model(input int x, input int y, input int im, input int sel,
                                input logic [3:0] en,
                                output int bus, output int carry, output bit active);
    int b;
    if (sel == 0)      b = y;
    else if (sel == 1) b = im;
    else if (sel == 2) b = 1;
    else               b = 0;
    active = 1'b1;
    carry  = 0;
    if (!en[3]) begin
      bus   = (x + b) % 16;
      carry = (x + b) / 16;
    end else if (!en[2]) bus = x & b;
    else if (!en[1])     bus = x | b;
    else if (!en[0])     bus = x ^ b;
    else begin
      bus    = 0;
      active = 1'b0;
    end
  endfunction

  // Present one cycle of stimulus, check the bus combinationally, then the flags after the edge
  task automatic apply(input string tag, input logic [3:0] x, input logic [3:0] y,
                       input logic [3:0] im, input logic [1:0] sel,
                       input logic [3:0] en, input logic rst);
    int exp_bus, exp_c;
    bit act;
    @(negedge tb_CLK);
    tb_X = x; tb_Y = y; tb_IM = im; tb_SEL = sel; tb_RST = rst;
    {tb_nFA_EN, tb_nAND_EN, tb_nOR_EN, tb_nXOR_EN} = en;
    model(int'(x), int'(y), int'(im), int'(sel), en, exp_bus, exp_c, act);
    #1;
    check_val({tag, ".bus"}, {1'b0, tb_STOREBUS}, 5'(exp_bus));
    if (rst) begin
      model_z = 1'b0;
      model_c = 1'b0;
    end else if (act) begin
      model_z = (exp_bus == 0);
      model_c = (exp_c != 0);
    end
    @(posedge tb_CLK);
    #1;
    check_val({tag, ".z"}, {4'b0000, tb_Z_FLAG}, {4'b0000, model_z});
    check_val({tag, ".c"}, {4'b0000, tb_C_FLAG}, {4'b0000, model_c});
  endtask

  // Stimulus sequence: test-plan scenarios with literal expectations, then random
  initial begin
    tb_RST = 1'b1; tb_X = 4'b0000; tb_Y = 4'b0000; tb_IM = 4'b0000; tb_SEL = 2'b00;
    {tb_nFA_EN, tb_nAND_EN, tb_nOR_EN, tb_nXOR_EN} = 4'b1111;

    // 1. Reset held with an add requested; flags stay clear
    for (int i = 0; i < 4; i++) apply("rst", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b0111, 1'b1);
    apply("rel_add", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b0111, 1'b0);
    check_val("t1_bus", {1'b0, tb_STOREBUS}, 5'b01111);

    // 2. Immediate operand, each operation
    apply("im_add", 4'b0101, 4'b0000, 4'b1100, 2'b01, 4'b0111, 1'b0);
    check_val("t2_add_bus", {1'b0, tb_STOREBUS}, 5'b00001);
    check_val("t2_add_c", {4'b0000, tb_C_FLAG}, 5'b00001);
    apply("im_and", 4'b0101, 4'b0000, 4'b1100, 2'b01, 4'b1011, 1'b0);
    check_val("t2_and_bus", {1'b0, tb_STOREBUS}, 5'b00100);
    apply("im_or", 4'b0101, 4'b0000, 4'b1100, 2'b01, 4'b1101, 1'b0);
    check_val("t2_or_bus", {1'b0, tb_STOREBUS}, 5'b01101);
    apply("im_xor", 4'b0101, 4'b0000, 4'b1100, 2'b01, 4'b1110, 1'b0);
    check_val("t2_xor_bus", {1'b0, tb_STOREBUS}, 5'b01001);

    // 3. Register operand logic ops; AND result zero sets Z
    apply("y_and", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b1011, 1'b0);
    check_val("t3_and_z", {4'b0000, tb_Z_FLAG}, 5'b00001);
    apply("y_or", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b1101, 1'b0);
    apply("y_xor", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b1110, 1'b0);

    // 4. Carry-producing add, then idle for 3 cycles: flags hold
    apply("c_add", 4'b1111, 4'b0011, 4'b0000, 2'b00, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) apply("idle", 4'b1001, 4'b0110, 4'b0101, 2'b01, 4'b1111, 1'b0);
    check_val("t4_hold_c", {4'b0000, tb_C_FLAG}, 5'b00001);

    // 5. Priority decode
    apply("pri_fa", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b0011, 1'b0);
    apply("pri_or", 4'b0101, 4'b1010, 4'b0000, 2'b00, 4'b1100, 1'b0);
    apply("pri_all", 4'b0110, 4'b0011, 4'b0000, 2'b00, 4'b0000, 1'b0);

    // 6. Increment wraps to zero, then reset on the following cycle
    apply("inc_wrap", 4'b1111, 4'b0000, 4'b0000, 2'b10, 4'b0111, 1'b0);
    check_val("t6_z", {4'b0000, tb_Z_FLAG}, 5'b00001);
    check_val("t6_c", {4'b0000, tb_C_FLAG}, 5'b00001);
    apply("rst_mid", 4'b1111, 4'b0000, 4'b0000, 2'b10, 4'b0111, 1'b1);
    apply("pass_x", 4'b0000, 4'b0111, 4'b0111, 2'b11, 4'b1101, 1'b0);

    // Randomized stimulus with occasional reset
    for (int i = 0; i < 400; i++) begin
      apply("rand", 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom),
            4'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
